plic_hart_arb: RTL and testbench
================================

Name: plic_hart_arb

Overview:
Per-hart interrupt arbiter for the PLIC. It scans all interrupt kids in fixed-size groups, finds the highest-priority enabled pending request, and compares it against the hart threshold to drive the hart interrupt line. It also serves claim reads and completion writes by issuing one-hot claim and complete pulses back to the kids. It sits between the kid array and the hart register block.

Parameters:
INT_NUM, 64, number of interrupt sources including reserved ID 0; multiple of SCAN_WIDTH.
PRIO_BIT, 5, priority width.
ID_BIT, 6, interrupt ID width; equals clog2(INT_NUM).
SCAN_WIDTH, 8, kids compared per cycle. NUM_GRP = INT_NUM/SCAN_WIDTH.

Ports:
plic_clk  in  1  block clock.
plicrst  in  1  asynchronous reset, active-high.
kid_arb_int_req  in  INT_NUM  per-kid request: pending, not active, priority nonzero.
kid_arb_int_prio  in  INT_NUM*PRIO_BIT  flattened priorities; kid i occupies bits [i*PRIO_BIT +: PRIO_BIT].
kid_arb_int_pulse  in  INT_NUM  per-kid new-edge pulse.
hreg_arb_ie  in  INT_NUM  hart enable bits.
hreg_arb_th  in  PRIO_BIT  hart threshold.
hreg_arb_claim_req  in  1  claim read strobe, one cycle.
hreg_arb_cmplt_req  in  1  completion write strobe.
hreg_arb_cmplt_id  in  ID_BIT  completion ID.
arb_hreg_claim_id  out  ID_BIT  claim read data.
arb_hreg_claim_kid  out  INT_NUM  one-hot claim pulse to kids.
arb_hreg_cmplt_kid  out  INT_NUM  one-hot complete pulse to kids.
arb_ctrl_int_vld  out  1  hart interrupt request.
arb_busy  out  1  high while state is FLUSH.

Behaviour:
- Eligibility: elig[i] = kid_arb_int_req[i] & hreg_arb_ie[i] & (i != 0). Bit 0 is always ignored.
- FSM states: IDLE, SCAN, FLUSH. Reset state is IDLE.
  - IDLE goes to SCAN on the first cycle after reset deasserts.
  - SCAN runs continuously.
  - A claim that grants goes to FLUSH for exactly one cycle, then back to SCAN with grp = 0.
- SCAN datapath:
  - Group counter grp runs 0..NUM_GRP-1 and wraps.
  - Each cycle, compute the max-priority eligible entry in group grp, then merge it with the running best (run_id, run_prio).
  - Replace the running best only on strictly greater priority, so ties go to the lowest ID.
  - When grp = 0, the running best is seeded from the group result; it is not merged.
- Commit: in the grp = NUM_GRP-1 cycle, the merged result is registered into best_id_q/best_prio_q at the clock edge. Pass latency is NUM_GRP cycles; a request is visible at most 2*NUM_GRP+1 cycles after it asserts.
- No eligible kid in a pass: commit best_id_q = 0 and best_prio_q = 0.
- Hart interrupt line: arb_ctrl_int_vld = (best_id_q != 0) & (best_prio_q > hreg_arb_th). This is combinational, so a threshold change takes effect the same cycle.
- Claim:
  - arb_hreg_claim_id = arb_ctrl_int_vld ? best_id_q : 0, combinational.
  - On hreg_arb_claim_req with arb_ctrl_int_vld high, arb_hreg_claim_kid[best_id_q] pulses in the same cycle.
  - At the same edge: best_id_q and best_prio_q clear to 0, grp clears, and the FSM enters FLUSH.
  - A claim with arb_ctrl_int_vld low returns 0, emits no pulse, and leaves state unchanged.
  - A claim during FLUSH returns 0.
- Complete: on hreg_arb_cmplt_req with 1 <= hreg_arb_cmplt_id < INT_NUM, arb_hreg_cmplt_kid[id] pulses for one cycle, registered (1 cycle after the strobe). ID 0 or an out-of-range ID is ignored.
- Simultaneous claim and complete: both are serviced independently. If they name the same ID, the kid resolves it.
- Reset values: all outputs 0, best_id_q/best_prio_q 0, grp 0, state IDLE. Asynchronous reset mid-pass discards the running best.

Optional Feature:
Macro PLIC_ARB_PULSE_RESTART_EN.
- Defined: in SCAN, any bit of kid_arb_int_pulse set while grp != 0 restarts the pass at grp = 0 next cycle and keeps the committed result. A restart_done flag allows at most one restart per pass; it clears on commit, which prevents starvation.
- Undefined: kid_arb_int_pulse is unused and passes run uninterrupted.

Decomposition:
- Package plic_arb_pkg holds the state encodings (IDLE = 2'b00, SCAN = 2'b01, FLUSH = 2'b10) and the derived constants NUM_GRP and GRP_BIT = clog2(NUM_GRP).
- One sub-module, plic_arb_grp_max: combinational SCAN_WIDTH-way max that outputs the local index, priority, and a valid flag, with lowest index winning ties.

Test Plan:
- Reset then idle: no requests, all IE=1 -> arb_ctrl_int_vld=0, claim returns 0, no claim pulse.
- Priority/tie: kid 5 prio 3, kid 40 prio 7, kid 41 prio 7, th=2 -> after at most 2*NUM_GRP+1 cycles int_vld=1 and claim_id=40; claim_kid[40] pulses; the next cycle is FLUSH with int_vld=0.
- Threshold: kid 9 prio 4 -> th=4 gives int_vld=0; th changed to 3 gives int_vld=1 the same cycle.
- Complete: cmplt_id=9 -> cmplt_kid[9] pulses one cycle later; cmplt_id=0 or 64 -> no pulse.
- Enable mask and ID 0: req[0]=1 prio 31, kid 12 prio 1 with ie[12]=0 -> int_vld=0; set ie[12] -> claim_id=12.
- With PLIC_ARB_PULSE_RESTART_EN: pulse at grp=3 -> grp=0 next cycle; a second pulse in the same pass -> no restart.

Source files
------------

// File: rtl/plic_arb_pkg.sv
// Shared constants and FSM encoding for the PLIC per-hart arbiter.
package plic_arb_pkg;

  localparam int DEF_INT_NUM    = 64;
  localparam int DEF_PRIO_BIT   = 5;
  localparam int DEF_ID_BIT     = 6;
  localparam int DEF_SCAN_WIDTH = 8;

  localparam int NUM_GRP = DEF_INT_NUM / DEF_SCAN_WIDTH;
  localparam int GRP_BIT = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    FLUSH = 2'b10
  } arb_state_e;

endpackage

// File: rtl/plic_arb_grp_max.sv
// Combinational max over one scan group; the lowest local index wins ties.
module plic_arb_grp_max #(
  parameter int SCAN_WIDTH = 8,
  parameter int PRIO_BIT   = 5,
  parameter int IDX_BIT    = 3
) (
  input  logic [SCAN_WIDTH-1:0]          elig,
  input  logic [SCAN_WIDTH*PRIO_BIT-1:0] prio,
  output logic [IDX_BIT-1:0]             idx,
  output logic [PRIO_BIT-1:0]            max_prio,
  output logic                           vld
);

  always_comb begin
    idx      = '0;
    max_prio = '0;
    vld      = 1'b0;
    for (int i = 0; i < SCAN_WIDTH; i++) begin
      if (elig[i] && (!vld || (prio[i*PRIO_BIT +: PRIO_BIT] > max_prio))) begin
        vld      = 1'b1;
        idx      = IDX_BIT'(i);
        max_prio = prio[i*PRIO_BIT +: PRIO_BIT];
      end
    end
  end

endmodule

// File: rtl/plic_hart_arb.sv
// Per-hart PLIC arbiter: grouped priority scan, threshold compare, claim/complete pulses.
// Optional PLIC_ARB_PULSE_RESTART_EN: a new kid edge restarts the current scan pass once.
module plic_hart_arb
  import plic_arb_pkg::*;
#(
  parameter int INT_NUM    = DEF_INT_NUM,
  parameter int PRIO_BIT   = DEF_PRIO_BIT,
  parameter int ID_BIT     = DEF_ID_BIT,
  parameter int SCAN_WIDTH = DEF_SCAN_WIDTH
) (
  input  logic                         plic_clk,
  input  logic                         plicrst,
  input  logic [INT_NUM-1:0]           kid_arb_int_req,
  input  logic [INT_NUM*PRIO_BIT-1:0]  kid_arb_int_prio,
  input  logic [INT_NUM-1:0]           kid_arb_int_pulse,
  input  logic [INT_NUM-1:0]           hreg_arb_ie,
  input  logic [PRIO_BIT-1:0]          hreg_arb_th,
  input  logic                         hreg_arb_claim_req,
  input  logic                         hreg_arb_cmplt_req,
  input  logic [ID_BIT-1:0]            hreg_arb_cmplt_id,
  output logic [ID_BIT-1:0]            arb_hreg_claim_id,
  output logic [INT_NUM-1:0]           arb_hreg_claim_kid,
  output logic [INT_NUM-1:0]           arb_hreg_cmplt_kid,
  output logic                         arb_ctrl_int_vld,
  output logic                         arb_busy
);

  // state | meaning
  // IDLE  | one cycle after reset before scanning starts
  // SCAN  | walking groups, committing a winner every pass
  // FLUSH | one cycle after a granted claim, committed result cleared

  localparam int GRPS = INT_NUM / SCAN_WIDTH;
  localparam int GW   = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int LW   = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GRPS - 1);

  arb_state_e            state_q;
  logic [GW-1:0]         grp_q;
  logic [ID_BIT-1:0]     run_id_q, best_id_q, mrg_id, grp_id;
  logic [PRIO_BIT-1:0]   run_prio_q, best_prio_q, mrg_prio, loc_prio;
  logic [LW-1:0]         loc_idx;
  logic                  loc_vld;
  logic [INT_NUM-1:0]    elig, cmplt_next;
  logic                  grant, restart;

  always_comb begin
    elig    = kid_arb_int_req & hreg_arb_ie;
    elig[0] = 1'b0;
  end

  plic_arb_grp_max #(
    .SCAN_WIDTH (SCAN_WIDTH),
    .PRIO_BIT   (PRIO_BIT),
    .IDX_BIT    (LW)
  ) u_grp_max (
    .elig     (elig[grp_q*SCAN_WIDTH +: SCAN_WIDTH]),
    .prio     (kid_arb_int_prio[grp_q*SCAN_WIDTH*PRIO_BIT +: SCAN_WIDTH*PRIO_BIT]),
    .idx      (loc_idx),
    .max_prio (loc_prio),
    .vld      (loc_vld)
  );

  assign grp_id = ID_BIT'(int'(grp_q) * SCAN_WIDTH + int'(loc_idx));

  // Group 0 seeds the running best; later groups replace it only on strictly higher priority.
  always_comb begin
    mrg_id   = run_id_q;
    mrg_prio = run_prio_q;
    if (grp_q == '0) begin
      mrg_id   = loc_vld ? grp_id : '0;
      mrg_prio = loc_vld ? loc_prio : '0;
    end else if (loc_vld && (loc_prio > run_prio_q)) begin
      mrg_id   = grp_id;
      mrg_prio = loc_prio;
    end
  end

  assign arb_ctrl_int_vld  = (best_id_q != '0) && (best_prio_q > hreg_arb_th);
  assign arb_hreg_claim_id = arb_ctrl_int_vld ? best_id_q : '0;
  assign grant             = hreg_arb_claim_req && arb_ctrl_int_vld;
  assign arb_busy          = (state_q == FLUSH);

  always_comb begin
    arb_hreg_claim_kid = '0;
    if (grant) arb_hreg_claim_kid[best_id_q] = 1'b1;
  end

  always_comb begin
    cmplt_next = '0;
    if (hreg_arb_cmplt_req && (hreg_arb_cmplt_id != '0) && (int'(hreg_arb_cmplt_id) < INT_NUM))
      cmplt_next[hreg_arb_cmplt_id] = 1'b1;
  end

`ifdef PLIC_ARB_PULSE_RESTART_EN
  logic restart_done_q;

  assign restart = (state_q == SCAN) && !grant && (|kid_arb_int_pulse) &&
                   (grp_q != '0) && !restart_done_q;

  always_ff @(posedge plic_clk or posedge plicrst) begin
    if (plicrst) begin
      restart_done_q <= 1'b0;
    end else if (state_q == SCAN) begin
      if (grant || (!restart && (grp_q == LAST_GRP))) restart_done_q <= 1'b0;
      else if (restart)                               restart_done_q <= 1'b1;
    end
  end
`else
  logic unused_pulse;
  assign unused_pulse = ^kid_arb_int_pulse;
  assign restart      = 1'b0;
`endif

  always_ff @(posedge plic_clk or posedge plicrst) begin
    if (plicrst) begin
      state_q            <= IDLE;
      grp_q              <= '0;
      run_id_q           <= '0;
      run_prio_q         <= '0;
      best_id_q          <= '0;
      best_prio_q        <= '0;
      arb_hreg_cmplt_kid <= '0;
    end else begin
      arb_hreg_cmplt_kid <= cmplt_next;
      case (state_q)
        IDLE: state_q <= SCAN;
        SCAN: begin
          if (grant) begin
            state_q     <= FLUSH;
            grp_q       <= '0;
            run_id_q    <= '0;
            run_prio_q  <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
          end else if (restart) begin
            grp_q <= '0;
          end else begin
            run_id_q   <= mrg_id;
            run_prio_q <= mrg_prio;
            if (grp_q == LAST_GRP) begin
              best_id_q   <= mrg_id;
              best_prio_q <= mrg_prio;
              grp_q       <= '0;
            end else begin
              grp_q <= grp_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          state_q <= SCAN;
          grp_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_hart_arb.sv
// Directed self-checking bench for plic_hart_arb (default 64 kids, 8 per group).
module tb_plic_hart_arb;

  localparam int INT_NUM  = 64;
  localparam int PRIO_BIT = 5;
  localparam int ID_BIT   = 6;
  localparam int WAIT_CYC = 17;

  logic                        plic_clk = 1'b0;
  logic                        plicrst  = 1'b1;
  logic [INT_NUM-1:0]          kid_arb_int_req   = '0;
  logic [INT_NUM*PRIO_BIT-1:0] kid_arb_int_prio  = '0;
  logic [INT_NUM-1:0]          kid_arb_int_pulse = '0;
  logic [INT_NUM-1:0]          hreg_arb_ie       = '0;
  logic [PRIO_BIT-1:0]         hreg_arb_th       = '0;
  logic                        hreg_arb_claim_req = 1'b0;
  logic                        hreg_arb_cmplt_req = 1'b0;
  logic [ID_BIT-1:0]           hreg_arb_cmplt_id  = '0;
  logic [ID_BIT-1:0]           arb_hreg_claim_id;
  logic [INT_NUM-1:0]          arb_hreg_claim_kid;
  logic [INT_NUM-1:0]          arb_hreg_cmplt_kid;
  logic                        arb_ctrl_int_vld;
  logic                        arb_busy;

  int total  = 0;
  int passed = 0;
  logic [INT_NUM-1:0] exp_vec;

  always #5 plic_clk = ~plic_clk;

  plic_hart_arb dut (
    .plic_clk           (plic_clk),
    .plicrst            (plicrst),
    .kid_arb_int_req    (kid_arb_int_req),
    .kid_arb_int_prio   (kid_arb_int_prio),
    .kid_arb_int_pulse  (kid_arb_int_pulse),
    .hreg_arb_ie        (hreg_arb_ie),
    .hreg_arb_th        (hreg_arb_th),
    .hreg_arb_claim_req (hreg_arb_claim_req),
    .hreg_arb_cmplt_req (hreg_arb_cmplt_req),
    .hreg_arb_cmplt_id  (hreg_arb_cmplt_id),
    .arb_hreg_claim_id  (arb_hreg_claim_id),
    .arb_hreg_claim_kid (arb_hreg_claim_kid),
    .arb_hreg_cmplt_kid (arb_hreg_cmplt_kid),
    .arb_ctrl_int_vld   (arb_ctrl_int_vld),
    .arb_busy           (arb_busy)
  );

  task automatic set_prio(input int k, input int p);
    kid_arb_int_prio[k*PRIO_BIT +: PRIO_BIT] = PRIO_BIT'(p);
  endtask

  task automatic clear_kids();
    kid_arb_int_req  = '0;
    kid_arb_int_prio = '0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (arb_ctrl_int_vld !== 1'b0) $display("FAIL reset_int_vld got %b want 0", arb_ctrl_int_vld);
    else passed++;
    total++;
    if (arb_hreg_claim_id !== '0) $display("FAIL reset_claim_id got %0d want 0", arb_hreg_claim_id);
    else passed++;
    total++;
    if ((arb_hreg_claim_kid | arb_hreg_cmplt_kid) !== '0)
      $display("FAIL reset_kid_pulses got %h/%h want 0", arb_hreg_claim_kid, arb_hreg_cmplt_kid);
    else passed++;
    total++;
    if (arb_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", arb_busy);
    else passed++;
    @(negedge plic_clk);
    plicrst = 1'b0;
  endtask

  task automatic test_idle();
    hreg_arb_ie = '1;
    repeat (WAIT_CYC) @(negedge plic_clk);
    hreg_arb_claim_req = 1'b1;
    #1;
    total++;
    if (arb_ctrl_int_vld !== 1'b0) $display("FAIL idle_int_vld got %b want 0", arb_ctrl_int_vld);
    else passed++;
    total++;
    if (arb_hreg_claim_id !== '0 || arb_hreg_claim_kid !== '0)
      $display("FAIL idle_claim got id %0d kid %h want 0/0", arb_hreg_claim_id, arb_hreg_claim_kid);
    else passed++;
    @(negedge plic_clk);
    hreg_arb_claim_req = 1'b0;
    total++;
    if (arb_busy !== 1'b0) $display("FAIL idle_no_flush got %b want 0", arb_busy);
    else passed++;
  endtask

  task automatic test_priority_tie();
    clear_kids();
    set_prio(5, 3);  kid_arb_int_req[5]  = 1'b1;
    set_prio(40, 7); kid_arb_int_req[40] = 1'b1;
    set_prio(41, 7); kid_arb_int_req[41] = 1'b1;
    hreg_arb_th = 5'd2;
    repeat (WAIT_CYC) @(negedge plic_clk);
    total++;
    if (arb_ctrl_int_vld !== 1'b1 || arb_hreg_claim_id !== 6'd40)
      $display("FAIL tie_winner got vld %b id %0d want 1/40", arb_ctrl_int_vld, arb_hreg_claim_id);
    else passed++;
    hreg_arb_claim_req = 1'b1;
    #1;
    exp_vec = '0; exp_vec[40] = 1'b1;
    total++;
    if (arb_hreg_claim_kid !== exp_vec)
      $display("FAIL claim_pulse got %h want %h", arb_hreg_claim_kid, exp_vec);
    else passed++;
    @(negedge plic_clk);
    hreg_arb_claim_req   = 1'b0;
    kid_arb_int_req[40]  = 1'b0;
    total++;
    if (arb_busy !== 1'b1 || arb_ctrl_int_vld !== 1'b0)
      $display("FAIL flush_state got busy %b vld %b want 1/0", arb_busy, arb_ctrl_int_vld);
    else passed++;
    total++;
    if (arb_hreg_claim_kid !== '0) $display("FAIL claim_pulse_len got %h want 0", arb_hreg_claim_kid);
    else passed++;
    @(negedge plic_clk);
    total++;
    if (arb_busy !== 1'b0) $display("FAIL flush_one_cycle got %b want 0", arb_busy);
    else passed++;
    repeat (WAIT_CYC) @(negedge plic_clk);
    total++;
    if (arb_hreg_claim_id !== 6'd41) $display("FAIL next_winner got %0d want 41", arb_hreg_claim_id);
    else passed++;
  endtask

  task automatic test_threshold();
    clear_kids();
    set_prio(9, 4); kid_arb_int_req[9] = 1'b1;
    hreg_arb_th = 5'd4;
    repeat (WAIT_CYC) @(negedge plic_clk);
    total++;
    if (arb_ctrl_int_vld !== 1'b0) $display("FAIL th_equal got %b want 0", arb_ctrl_int_vld);
    else passed++;
    hreg_arb_th = 5'd3;
    #1;
    total++;
    if (arb_ctrl_int_vld !== 1'b1 || arb_hreg_claim_id !== 6'd9)
      $display("FAIL th_lower got vld %b id %0d want 1/9", arb_ctrl_int_vld, arb_hreg_claim_id);
    else passed++;
  endtask

  task automatic test_complete();
    @(negedge plic_clk);
    hreg_arb_cmplt_req = 1'b1;
    hreg_arb_cmplt_id  = 6'd9;
    #1;
    total++;
    if (arb_hreg_cmplt_kid !== '0) $display("FAIL cmplt_registered got %h want 0", arb_hreg_cmplt_kid);
    else passed++;
    @(negedge plic_clk);
    hreg_arb_cmplt_req = 1'b0;
    exp_vec = '0; exp_vec[9] = 1'b1;
    total++;
    if (arb_hreg_cmplt_kid !== exp_vec) $display("FAIL cmplt_9 got %h want %h", arb_hreg_cmplt_kid, exp_vec);
    else passed++;
    @(negedge plic_clk);
    total++;
    if (arb_hreg_cmplt_kid !== '0) $display("FAIL cmplt_len got %h want 0", arb_hreg_cmplt_kid);
    else passed++;
    hreg_arb_cmplt_req = 1'b1;
    hreg_arb_cmplt_id  = 6'd0;
    @(negedge plic_clk);
    hreg_arb_cmplt_req = 1'b0;
    total++;
    if (arb_hreg_cmplt_kid !== '0) $display("FAIL cmplt_id0 got %h want 0", arb_hreg_cmplt_kid);
    else passed++;
    hreg_arb_cmplt_req = 1'b1;
    hreg_arb_cmplt_id  = 6'd63;
    @(negedge plic_clk);
    hreg_arb_cmplt_req = 1'b0;
    exp_vec = '0; exp_vec[63] = 1'b1;
    total++;
    if (arb_hreg_cmplt_kid !== exp_vec) $display("FAIL cmplt_63 got %h want %h", arb_hreg_cmplt_kid, exp_vec);
    else passed++;
  endtask

  task automatic test_mask_id0();
    clear_kids();
    hreg_arb_th = 5'd0;
    set_prio(0, 31); kid_arb_int_req[0]  = 1'b1;
    set_prio(12, 1); kid_arb_int_req[12] = 1'b1;
    hreg_arb_ie = '1;
    hreg_arb_ie[12] = 1'b0;
    repeat (WAIT_CYC) @(negedge plic_clk);
    total++;
    if (arb_ctrl_int_vld !== 1'b0 || arb_hreg_claim_id !== '0)
      $display("FAIL mask_none got vld %b id %0d want 0/0", arb_ctrl_int_vld, arb_hreg_claim_id);
    else passed++;
    hreg_arb_ie[12] = 1'b1;
    repeat (WAIT_CYC) @(negedge plic_clk);
    total++;
    if (arb_ctrl_int_vld !== 1'b1 || arb_hreg_claim_id !== 6'd12)
      $display("FAIL mask_enabled got vld %b id %0d want 1/12", arb_ctrl_int_vld, arb_hreg_claim_id);
    else passed++;
  endtask

  task automatic test_back_to_back();
    hreg_arb_claim_req = 1'b1;
    hreg_arb_cmplt_req = 1'b1;
    hreg_arb_cmplt_id  = 6'd12;
    #1;
    exp_vec = '0; exp_vec[12] = 1'b1;
    total++;
    if (arb_hreg_claim_kid !== exp_vec) $display("FAIL b2b_claim got %h want %h", arb_hreg_claim_kid, exp_vec);
    else passed++;
    @(negedge plic_clk);
    hreg_arb_claim_req = 1'b0;
    hreg_arb_cmplt_req = 1'b0;
    total++;
    if (arb_hreg_cmplt_kid !== exp_vec || arb_busy !== 1'b1)
      $display("FAIL b2b_cmplt got %h busy %b want %h/1", arb_hreg_cmplt_kid, arb_busy, exp_vec);
    else passed++;
    hreg_arb_claim_req = 1'b1;
    #1;
    total++;
    if (arb_hreg_claim_id !== '0 || arb_hreg_claim_kid !== '0)
      $display("FAIL claim_in_flush got id %0d kid %h want 0/0", arb_hreg_claim_id, arb_hreg_claim_kid);
    else passed++;
    @(negedge plic_clk);
    hreg_arb_claim_req = 1'b0;
  endtask

`ifdef PLIC_ARB_PULSE_RESTART_EN
  task automatic test_restart();
    int n;
    n = 0;
    while (dut.grp_q !== 3'd3 && n < 40) begin @(negedge plic_clk); n++; end
    total++;
    if (n >= 40) $display("FAIL restart_wait_grp3 timed out");
    else passed++;
    kid_arb_int_pulse[7] = 1'b1;
    @(negedge plic_clk);
    kid_arb_int_pulse = '0;
    total++;
    if (dut.grp_q !== 3'd0) $display("FAIL restart_first got grp %0d want 0", dut.grp_q);
    else passed++;
    n = 0;
    while (dut.grp_q !== 3'd2 && n < 40) begin @(negedge plic_clk); n++; end
    kid_arb_int_pulse[7] = 1'b1;
    @(negedge plic_clk);
    kid_arb_int_pulse = '0;
    total++;
    if (dut.grp_q !== 3'd3) $display("FAIL restart_second got grp %0d want 3", dut.grp_q);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_priority_tie();
    test_threshold();
    test_complete();
    test_mask_id0();
    test_back_to_back();
`ifdef PLIC_ARB_PULSE_RESTART_EN
    test_restart();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
